fifo_width_conv: RTL and testbench

FIFO_WIDTH_CONV -- requirements
Module: fifo_width_conv

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_ram.sv | 30 +++
 rtl/fifo_width_conv.sv | 105 ++++++++++
 tb/tb_fifo_width_conv.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the width-converting FIFO.
package fifo_pkg;

  localparam int FIFO_IN_W  = 32;
  localparam int FIFO_RATIO = 2;
  localparam int FIFO_DEPTH = 8;

  // Bits needed to hold an occupancy count from 0 up to and including depth.
  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array: one multi-slice write port, one asynchronous read port.
module fifo_ram #(
  parameter int OUT_W = 16,
  parameter int DEPTH = 8,
  parameter int RATIO = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [RATIO*OUT_W-1:0] wr_data,
  input  logic [AW-1:0]          rd_addr,
  output logic [OUT_W-1:0]       rd_data
);

  logic [OUT_W-1:0] mem_q [DEPTH];

  // Write RATIO slices into consecutive locations; the AW-bit address sum wraps modulo DEPTH.
  // NOTE: storage carries no reset -- validity is tracked by the level counter, so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < RATIO; i++) begin
        mem_q[wr_addr + AW'(i)] <= wr_data[i*OUT_W +: OUT_W];
      end
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_width_conv.sv
// Width-down-converting FIFO: accepts IN_W words, emits RATIO OUT_W slices each.
module fifo_width_conv
  import fifo_pkg::*;
#(
  parameter int IN_W      = FIFO_IN_W,
  parameter int RATIO     = FIFO_RATIO,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int MSB_FIRST = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [IN_W-1:0]             data_in,
  input  logic                        data_in_vld,
  output logic                        data_in_rdy,
  output logic [IN_W/RATIO-1:0]       data_out,
  output logic                        data_out_vld,
  input  logic                        data_out_rdy,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam int OUT_W = IN_W / RATIO;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = level_w(DEPTH);
  localparam logic [LW-1:0] RDY_MAX = LW'(DEPTH - RATIO);

  // Reject parameter sets the pointer arithmetic cannot support.
  if (RATIO < 1 || (IN_W % RATIO) != 0 || DEPTH < 2 * RATIO ||
      (DEPTH % RATIO) != 0 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    $error("fifo_width_conv: illegal IN_W/RATIO/DEPTH combination");
  end

  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic [RATIO*OUT_W-1:0] wr_slices;
  logic [OUT_W-1:0]       rd_data;
  logic                   push, pop;

  // Ready only depends on stored occupancy, never on a same-cycle pop.
  assign data_in_rdy  = (level_q <= RDY_MAX);
  assign data_out_vld = (level_q != '0);
  assign data_out     = data_out_vld ? rd_data : '0;
  assign level        = level_q;
  assign push         = data_in_vld && data_in_rdy;
  assign pop          = data_out_vld && data_out_rdy;

  // Order the input slices so slice i lands at wr_ptr+i in emission order.
  always_comb begin
    wr_slices = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (MSB_FIRST != 0) begin
        wr_slices[i*OUT_W +: OUT_W] = data_in[(RATIO-1-i)*OUT_W +: OUT_W];
      end else begin
        wr_slices[i*OUT_W +: OUT_W] = data_in[i*OUT_W +: OUT_W];
      end
    end
  end

  // Next-state pointers and level; flush wins over any same-cycle push or pop.
  // NOTE: every output gets a default first, so no path through the block can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(RATIO);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + (push ? LW'(RATIO) : '0) - (pop ? LW'(1) : '0);
    end
  end

  // Control state registers, cleared asynchronously.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  fifo_ram #(
    .OUT_W (OUT_W),
    .DEPTH (DEPTH),
    .RATIO (RATIO),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push && !flush),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_slices),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_fifo_width_conv.sv
// Directed bench for fifo_width_conv: vector table plus multi-cycle sequences.
module tb_fifo_width_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] data_in;
  logic        data_in_vld;
  logic        data_out_rdy;

  logic        in_rdy;
  logic [15:0] dout;
  logic        dout_vld;
  logic [3:0]  lvl;

  logic        l_in_rdy, m_in_rdy;
  logic [7:0]  l_dout, m_dout;
  logic        l_vld, m_vld;
  logic [3:0]  l_lvl, m_lvl;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fifo_width_conv dut (
    .clk (clk), .rst (rst), .flush (flush),
    .data_in (data_in), .data_in_vld (data_in_vld), .data_in_rdy (in_rdy),
    .data_out (dout), .data_out_vld (dout_vld), .data_out_rdy (data_out_rdy),
    .level (lvl)
  );

  fifo_width_conv #(.IN_W(32), .RATIO(4), .DEPTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk (clk), .rst (rst), .flush (flush),
    .data_in (data_in), .data_in_vld (data_in_vld), .data_in_rdy (l_in_rdy),
    .data_out (l_dout), .data_out_vld (l_vld), .data_out_rdy (data_out_rdy),
    .level (l_lvl)
  );

  fifo_width_conv #(.IN_W(32), .RATIO(4), .DEPTH(8), .MSB_FIRST(1)) dut_msb (
    .clk (clk), .rst (rst), .flush (flush),
    .data_in (data_in), .data_in_vld (data_in_vld), .data_in_rdy (m_in_rdy),
    .data_out (m_dout), .data_out_vld (m_vld), .data_out_rdy (data_out_rdy),
    .level (m_lvl)
  );

  typedef struct {
    logic        fl;
    logic        vld;
    logic [31:0] din;
    logic        rdy;
    logic [3:0]  e_lvl;
    logic        e_vld;
    logic [15:0] e_dout;
    logic        e_irdy;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mkv(logic fl, logic vld, logic [31:0] din, logic rdy,
                               logic [3:0] e_lvl, logic e_vld, logic [15:0] e_dout,
                               logic e_irdy);
    vec_t r;
    r.fl = fl; r.vld = vld; r.din = din; r.rdy = rdy;
    r.e_lvl = e_lvl; r.e_vld = e_vld; r.e_dout = e_dout; r.e_irdy = e_irdy;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic vld, input logic [31:0] din, input logic rdy);
    flush = fl; data_in_vld = vld; data_in = din; data_out_rdy = rdy;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Safety net: never let the run hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] q[$];
    int pushed, cyc;
    logic pu, po;
    logic [31:0] w;
    logic [7:0] exp_l[4];
    logic [7:0] exp_m[4];

    drive(1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    #2;
    check("reset_vld", {31'b0, dout_vld}, 32'd0);
    check("reset_level", {28'b0, lvl}, 32'd0);
    check("reset_in_rdy", {31'b0, in_rdy}, 32'd1);
    check("reset_dout", {16'b0, dout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // fl vld din rdy | level vld dout in_rdy  (expectations are pre-edge state)
    vq.push_back(mkv(0, 1, 32'hAAAA_5555, 1, 0, 0, 16'h0000, 1));
    vq.push_back(mkv(0, 0, 32'h0,         1, 2, 1, 16'hAAAA, 1));
    vq.push_back(mkv(0, 0, 32'h0,         1, 1, 1, 16'h5555, 1));
    vq.push_back(mkv(0, 0, 32'h0,         0, 0, 0, 16'h0000, 1));
    vq.push_back(mkv(0, 1, 32'h0001_0002, 0, 0, 0, 16'h0000, 1));
    vq.push_back(mkv(0, 1, 32'h0003_0004, 0, 2, 1, 16'h0001, 1));
    vq.push_back(mkv(0, 1, 32'h0005_0006, 0, 4, 1, 16'h0001, 1));
    vq.push_back(mkv(0, 1, 32'h0007_0008, 0, 6, 1, 16'h0001, 1));
    vq.push_back(mkv(0, 1, 32'h0009_000A, 0, 8, 1, 16'h0001, 0));
    vq.push_back(mkv(0, 1, 32'h0009_000A, 0, 8, 1, 16'h0001, 0));
    vq.push_back(mkv(0, 0, 32'h0,         1, 8, 1, 16'h0001, 0));
    vq.push_back(mkv(0, 0, 32'h0,         1, 7, 1, 16'h0002, 0));
    vq.push_back(mkv(0, 0, 32'h0,         0, 6, 1, 16'h0003, 1));
    vq.push_back(mkv(0, 1, 32'h000B_000C, 1, 6, 1, 16'h0003, 1));
    vq.push_back(mkv(0, 0, 32'h0,         0, 7, 1, 16'h0004, 0));
    vq.push_back(mkv(0, 0, 32'h0,         1, 7, 1, 16'h0004, 0));
    vq.push_back(mkv(0, 0, 32'h0,         1, 6, 1, 16'h0005, 1));
    vq.push_back(mkv(0, 0, 32'h0,         1, 5, 1, 16'h0006, 1));
    vq.push_back(mkv(0, 0, 32'h0,         1, 4, 1, 16'h0007, 1));
    vq.push_back(mkv(0, 0, 32'h0,         1, 3, 1, 16'h0008, 1));
    vq.push_back(mkv(0, 0, 32'h0,         1, 2, 1, 16'h000B, 1));
    vq.push_back(mkv(0, 0, 32'h0,         1, 1, 1, 16'h000C, 1));
    vq.push_back(mkv(0, 0, 32'h0,         0, 0, 0, 16'h0000, 1));
    vq.push_back(mkv(0, 1, 32'h1111_2222, 0, 0, 0, 16'h0000, 1));
    vq.push_back(mkv(0, 1, 32'h3333_4444, 0, 2, 1, 16'h1111, 1));
    vq.push_back(mkv(0, 1, 32'h5555_6666, 1, 4, 1, 16'h1111, 1));
    vq.push_back(mkv(1, 1, 32'h7777_8888, 1, 5, 1, 16'h2222, 1));
    vq.push_back(mkv(0, 0, 32'h0,         1, 0, 0, 16'h0000, 1));
    vq.push_back(mkv(0, 1, 32'hABCD_EF01, 1, 0, 0, 16'h0000, 1));
    vq.push_back(mkv(0, 0, 32'h0,         1, 2, 1, 16'hABCD, 1));
    vq.push_back(mkv(0, 0, 32'h0,         1, 1, 1, 16'hEF01, 1));
    vq.push_back(mkv(0, 0, 32'h0,         0, 0, 0, 16'h0000, 1));

    foreach (vq[i]) begin
      drive(vq[i].fl, vq[i].vld, vq[i].din, vq[i].rdy);
      #1;
      check($sformatf("v%0d_level", i), {28'b0, lvl}, {28'b0, vq[i].e_lvl});
      check($sformatf("v%0d_vld", i), {31'b0, dout_vld}, {31'b0, vq[i].e_vld});
      check($sformatf("v%0d_dout", i), {16'b0, dout}, {16'b0, vq[i].e_dout});
      check($sformatf("v%0d_in_rdy", i), {31'b0, in_rdy}, {31'b0, vq[i].e_irdy});
      @(negedge clk);
    end

    // Asynchronous reset in the middle of traffic at level 5.
    drive(0, 1, 32'h0101_0202, 0); @(negedge clk);
    drive(0, 1, 32'h0303_0404, 0); @(negedge clk);
    drive(0, 1, 32'h0505_0606, 0); @(negedge clk);
    drive(0, 0, 32'h0,         1); @(negedge clk);
    drive(0, 0, 32'h0,         0);
    #1;
    check("pre_rst_level", {28'b0, lvl}, 32'd5);
    rst = 1'b1;
    #1;
    check("mid_rst_vld", {31'b0, dout_vld}, 32'd0);
    check("mid_rst_level", {28'b0, lvl}, 32'd0);
    check("mid_rst_in_rdy", {31'b0, in_rdy}, 32'd1);
    check("mid_rst_dout", {16'b0, dout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 32'hDEAD_BEEF, 0); @(negedge clk);
    drive(0, 0, 32'h0, 0);
    #1;
    check("post_rst_level", {28'b0, lvl}, 32'd2);
    check("post_rst_dout", {16'b0, dout}, 32'h0000_DEAD);

    // Twenty random words through the pointer wrap, checked against a slice queue.
    do_reset();
    pushed = 0;
    cyc = 0;
    while ((pushed < 20 || q.size() != 0) && cyc < 600) begin
      w = $urandom;
      drive(0, (pushed < 20) && ($urandom_range(0, 3) != 0), w, $urandom_range(0, 2) != 0);
      #1;
      check("rand_level", {28'b0, lvl}, q.size());
      check("rand_in_rdy", {31'b0, in_rdy}, {31'b0, q.size() <= 6});
      if (q.size() != 0) check("rand_dout", {16'b0, dout}, {16'b0, q[0]});
      else check("rand_empty_dout", {16'b0, dout}, 32'd0);
      pu = data_in_vld && (q.size() <= 6);
      po = (q.size() != 0) && data_out_rdy;
      if (po) void'(q.pop_front());
      if (pu) begin
        q.push_back(w[31:16]);
        q.push_back(w[15:0]);
        pushed++;
      end
      @(negedge clk);
      cyc++;
    end
    check("rand_drained", {31'b0, (pushed == 20) && (q.size() == 0)}, 32'd1);

    // Four-way split, both slice orders.
    do_reset();
    exp_l = '{8'h44, 8'h33, 8'h22, 8'h11};
    exp_m = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive(0, 1, 32'h1122_3344, 1); @(negedge clk);
    drive(0, 0, 32'h0, 1);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("r4_lsb_dout%0d", k), {24'b0, l_dout}, {24'b0, exp_l[k]});
      check($sformatf("r4_msb_dout%0d", k), {24'b0, m_dout}, {24'b0, exp_m[k]});
      check($sformatf("r4_level%0d", k), {28'b0, l_lvl}, 4 - k);
      @(negedge clk);
    end
    #1;
    check("r4_empty_vld", {30'b0, l_vld, m_vld}, 32'd0);
    check("r4_in_rdy", {30'b0, l_in_rdy, m_in_rdy}, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
